fifo_frame_reader: RTL and testbench

- Consumer-side engine that drains the team's synchronous FIFO and presents its contents to the DSA as a framed valid/ready stream.
- The producer writes length-prefixed frames into the FIFO. Each frame is one header word followed by LEN payload words.
- This block issues FIFO reads, absorbs the 1-cycle SRAM read latency, and strips the header. It forwards the payload with last/tag sideband.

---
 rtl/fifo_frame_pkg.sv | 26 ++
 rtl/frame_rd_buf.sv | 73 +++++++
 rtl/fifo_frame_reader.sv | 126 ++++++++++++
 tb/tb_fifo_frame_reader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_pkg.sv
// Shared state encoding and header-field helpers for the FIFO frame reader.
// Header words carry the payload length in the low bits and the frame tag above it.
package fifo_frame_pkg;

    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

    localparam int LEN_WIDTH_DEF = 16;
    localparam int MAX_WORD      = 64;

    // Helpers work on a zero-extended word so any FIFO_WIDTH up to MAX_WORD fits.
    function automatic logic [MAX_WORD-1:0] hdr_len(input logic [MAX_WORD-1:0] word,
                                                    input int len_w);
        logic [MAX_WORD-1:0] mask;
        mask = (64'd1 << len_w) - 64'd1;
        return word & mask;
    endfunction

    function automatic logic [MAX_WORD-1:0] hdr_tag(input logic [MAX_WORD-1:0] word,
                                                    input int len_w);
        return word >> len_w;
    endfunction

endpackage

// File: rtl/frame_rd_buf.sv
// Two-entry word buffer that absorbs the FIFO read latency in front of the frame parser.
// slot0 is always the head; a simultaneous push and pop are both honoured.
module frame_rd_buf
    import fifo_frame_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       occ_q, occ_d;
    logic             do_pop;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        occ_d   = occ_q;
        do_pop  = pop && (occ_q != 2'd0);
        case (occ_q)
            2'd0: begin
                if (push) begin
                    slot0_d = push_data;
                    occ_d   = 2'd1;
                end
            end
            2'd1: begin
                if (push && do_pop) begin
                    slot0_d = push_data;
                end else if (push) begin
                    slot1_d = push_data;
                    occ_d   = 2'd2;
                end else if (do_pop) begin
                    occ_d   = 2'd0;
                end
            end
            default: begin
                // Full: a pop shifts slot1 forward, a concurrent push refills it.
                if (do_pop) begin
                    slot0_d = slot1_q;
                    if (push) begin
                        slot1_d = push_data;
                    end else begin
                        occ_d   = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            occ_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            occ_q   <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = slot0_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains length-prefixed frames from the synchronous FIFO and streams the payload
// to the DSA over valid/ready, stripping the header into last/tag sideband.
module fifo_frame_reader
    import fifo_frame_pkg::*;
#(
    parameter int FIFO_PTR   = 10,
    parameter int FIFO_WIDTH = 32,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fifo_empty,
    output logic                            fifo_read_en,
    input  logic [FIFO_WIDTH-1:0]           fifo_read_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [FIFO_WIDTH-1:0]           m_data,
    output logic                            m_last,
    output logic [FIFO_WIDTH-LEN_WIDTH-1:0] m_tag,
    output logic                            frame_done,
    output logic                            err_zero_len,
    output logic                            busy
);

    localparam int TAG_WIDTH = FIFO_WIDTH - LEN_WIDTH;

    if (FIFO_PTR < 1 || LEN_WIDTH < 1 || FIFO_WIDTH <= LEN_WIDTH || FIFO_WIDTH > MAX_WORD) begin : g_bad_cfg
        $error("fifo_frame_reader: unsupported parameter combination");
    end

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  inflight_q, inflight_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_zero_q, err_zero_d;

    logic [1:0]            occ;
    logic [FIFO_WIDTH-1:0] head;
    logic                  pop_now;
    logic                  handshake;
    logic [2:0]            pending;
    logic [LEN_WIDTH-1:0]  hdr_len_v;
    logic [TAG_WIDTH-1:0]  hdr_tag_v;

    frame_rd_buf #(
        .WIDTH(FIFO_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_data(fifo_read_data),
        .pop      (pop_now),
        .occ      (occ),
        .head_data(head)
    );

    // Read issue looks through this cycle's pop so a word per cycle is sustained.
    always_comb begin
        pop_now      = (occ != 2'd0) && ((state_q == HDR) || m_ready);
        handshake    = (state_q == PAYLOAD) && (occ != 2'd0) && m_ready;
        pending      = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop_now};
        fifo_read_en = !rst && !fifo_empty && (pending < 3'd2);
        hdr_len_v    = LEN_WIDTH'(hdr_len(MAX_WORD'(head), LEN_WIDTH));
        hdr_tag_v    = TAG_WIDTH'(hdr_tag(MAX_WORD'(head), LEN_WIDTH));
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        tag_d        = tag_q;
        inflight_d   = fifo_read_en;
        frame_done_d = 1'b0;
        err_zero_d   = 1'b0;
        case (state_q)
            HDR: begin
                if (occ != 2'd0) begin
                    if (hdr_len_v == '0) begin
                        err_zero_d = 1'b1;
                    end else begin
                        rem_d   = hdr_len_v;
                        tag_d   = hdr_tag_v;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (handshake) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        frame_done_d = 1'b1;
                        state_d      = HDR;
                    end
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HDR;
            rem_q        <= '0;
            tag_q        <= '0;
            inflight_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            tag_q        <= tag_d;
            inflight_q   <= inflight_d;
            frame_done_q <= frame_done_d;
            err_zero_q   <= err_zero_d;
        end
    end

    assign m_valid      = (state_q == PAYLOAD) && (occ != 2'd0);
    assign m_data       = head;
    assign m_last       = (state_q == PAYLOAD) && (rem_q == LEN_WIDTH'(1));
    assign m_tag        = tag_q;
    assign frame_done   = frame_done_q;
    assign err_zero_len = err_zero_q;
    assign busy         = (state_q == PAYLOAD) || (occ != 2'd0) || inflight_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: a small FIFO model feeds the reader and a
// monitor logs every handshake so each scenario can be checked against fixed values.
module tb_fifo_frame_reader;

    localparam int FW = 32;
    localparam int LW = 16;
    localparam int TW = FW - LW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic          fifo_read_en;
    logic [FW-1:0] fifo_read_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [FW-1:0] m_data;
    logic          m_last;
    logic [TW-1:0] m_tag;
    logic          frame_done;
    logic          err_zero_len;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_frame_reader #(
        .FIFO_PTR  (10),
        .FIFO_WIDTH(FW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_read_en  (fifo_read_en),
        .fifo_read_data(fifo_read_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .m_tag         (m_tag),
        .frame_done    (frame_done),
        .err_zero_len  (err_zero_len),
        .busy          (busy)
    );

    // Synchronous FIFO model with one-cycle read latency; hold masks it as empty.
    logic [FW-1:0] fmem [0:63];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            fcount = 0;
    logic          wr_en = 1'b0;
    logic [FW-1:0] wr_data = '0;
    logic          hold = 1'b0;
    logic [FW-1:0] rd_data_q = '0;

    always @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 0;
            rd_ptr    <= 0;
            fcount    <= 0;
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                fmem[wr_ptr % 64] <= wr_data;
                wr_ptr            <= wr_ptr + 1;
            end
            if (fifo_read_en) begin
                rd_data_q <= fmem[rd_ptr % 64];
                rd_ptr    <= rd_ptr + 1;
            end
            fcount <= fcount + (wr_en ? 1 : 0) - (fifo_read_en ? 1 : 0);
        end
    end

    assign fifo_empty     = (fcount == 0) || hold;
    assign fifo_read_data = rd_data_q;

    // Monitor samples mid-cycle, away from the active edge.
    int            cyc = 0;
    int            hs_count = 0;
    int            done_count = 0;
    int            err_count = 0;
    int            valid_cycles = 0;
    int            bad_read = 0;
    int            stall_viol = 0;
    int            read_count = 0;
    int            first_rd_cyc = 0;
    logic [FW-1:0] got_data[$];
    logic          got_last[$];
    logic [TW-1:0] got_tag[$];
    int            got_cyc[$];
    logic          prev_stall = 1'b0;
    logic [FW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [TW-1:0] prev_tag = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last || m_tag !== prev_tag))
                stall_viol = stall_viol + 1;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_tag.push_back(m_tag);
                got_cyc.push_back(cyc);
                hs_count = hs_count + 1;
            end
            if (m_valid) valid_cycles = valid_cycles + 1;
            if (frame_done) done_count = done_count + 1;
            if (err_zero_len) err_count = err_count + 1;
            if (fifo_read_en) begin
                if (read_count == 0) first_rd_cyc = cyc;
                read_count = read_count + 1;
                if (fifo_empty) bad_read = bad_read + 1;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_tag   = m_tag;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [FW-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks = checks + 1;
        assert (observed === expected)
        else begin
            errors = errors + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic clearLog();
        got_data.delete();
        got_last.delete();
        got_tag.delete();
        got_cyc.delete();
        hs_count     = 0;
        done_count   = 0;
        err_count    = 0;
        valid_cycles = 0;
        stall_viol   = 0;
        read_count   = 0;
        first_rd_cyc = 0;
    endtask

    task automatic checkIdle(input string pfx);
        checkOutput({pfx, "_m_valid"}, 64'(m_valid), 64'h0);
        checkOutput({pfx, "_m_data"}, 64'(m_data), 64'h0);
        checkOutput({pfx, "_m_last"}, 64'(m_last), 64'h0);
        checkOutput({pfx, "_m_tag"}, 64'(m_tag), 64'h0);
        checkOutput({pfx, "_frame_done"}, 64'(frame_done), 64'h0);
        checkOutput({pfx, "_err_zero_len"}, 64'(err_zero_len), 64'h0);
        checkOutput({pfx, "_busy"}, 64'(busy), 64'h0);
        checkOutput({pfx, "_fifo_read_en"}, 64'(fifo_read_en), 64'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst     = 1'b1;
        m_ready = 1'b0;
        step(3);
        rst = 1'b0;
        checkIdle("reset");

        $display("[TB] basic frame");
        clearLog();
        m_ready = 1'b1;
        applyStimulus(32'h00AB_0003);
        applyStimulus(32'h0000_0011);
        applyStimulus(32'h0000_0022);
        applyStimulus(32'h0000_0033);
        step(8);
        checkOutput("basic_hs", 64'(hs_count), 64'd3);
        checkOutput("basic_d0", 64'(got_data[0]), 64'h11);
        checkOutput("basic_d1", 64'(got_data[1]), 64'h22);
        checkOutput("basic_d2", 64'(got_data[2]), 64'h33);
        checkOutput("basic_last", 64'({got_last[2], got_last[1], got_last[0]}), 64'b100);
        checkOutput("basic_tag0", 64'(got_tag[0]), 64'h00AB);
        checkOutput("basic_tag2", 64'(got_tag[2]), 64'h00AB);
        checkOutput("basic_consec", 64'(got_cyc[2] - got_cyc[0]), 64'd2);
        checkOutput("basic_done", 64'(done_count), 64'd1);
        checkOutput("basic_err", 64'(err_count), 64'd0);

        $display("[TB] backpressure");
        clearLog();
        m_ready = 1'b0;
        applyStimulus(32'h00AB_0003);
        applyStimulus(32'h0000_0011);
        applyStimulus(32'h0000_0022);
        applyStimulus(32'h0000_0033);
        step(6);
        checkOutput("bp_hold_valid", 64'(m_valid), 64'h1);
        checkOutput("bp_hold_data", 64'(m_data), 64'h11);
        checkOutput("bp_no_read_full", 64'(fifo_read_en), 64'h0);
        checkOutput("bp_fifo_left", 64'(fcount), 64'd1);
        m_ready = 1'b1; step(1);
        m_ready = 1'b0; step(1);
        m_ready = 1'b0; step(1);
        m_ready = 1'b1; step(1);
        m_ready = 1'b0; step(1);
        m_ready = 1'b1; step(1);
        m_ready = 1'b0;
        step(3);
        checkOutput("bp_hs", 64'(hs_count), 64'd3);
        checkOutput("bp_d0", 64'(got_data[0]), 64'h11);
        checkOutput("bp_d1", 64'(got_data[1]), 64'h22);
        checkOutput("bp_d2", 64'(got_data[2]), 64'h33);
        checkOutput("bp_last", 64'({got_last[2], got_last[1], got_last[0]}), 64'b100);
        checkOutput("bp_stable", 64'(stall_viol), 64'd0);
        checkOutput("bp_done", 64'(done_count), 64'd1);

        $display("[TB] zero length header");
        clearLog();
        m_ready = 1'b1;
        applyStimulus(32'h0005_0000);
        applyStimulus(32'h0006_0001);
        applyStimulus(32'h0000_0044);
        step(8);
        checkOutput("zl_err", 64'(err_count), 64'd1);
        checkOutput("zl_valid_cycles", 64'(valid_cycles), 64'd1);
        checkOutput("zl_hs", 64'(hs_count), 64'd1);
        checkOutput("zl_data", 64'(got_data[0]), 64'h44);
        checkOutput("zl_last", 64'(got_last[0]), 64'h1);
        checkOutput("zl_tag", 64'(got_tag[0]), 64'h0006);
        checkOutput("zl_done", 64'(done_count), 64'd1);

        $display("[TB] throughput");
        hold = 1'b1;
        clearLog();
        m_ready = 1'b1;
        applyStimulus(32'h0001_0004);
        applyStimulus(32'h0000_00A1);
        applyStimulus(32'h0000_00A2);
        applyStimulus(32'h0000_00A3);
        applyStimulus(32'h0000_00A4);
        applyStimulus(32'h0002_0004);
        applyStimulus(32'h0000_00B1);
        applyStimulus(32'h0000_00B2);
        applyStimulus(32'h0000_00B3);
        applyStimulus(32'h0000_00B4);
        hold = 1'b0;
        step(16);
        checkOutput("tp_hs", 64'(hs_count), 64'd8);
        checkOutput("tp_within_12", 64'((got_cyc[7] - first_rd_cyc) <= 11), 64'h1);
        checkOutput("tp_done", 64'(done_count), 64'd2);
        checkOutput("tp_d3", 64'(got_data[3]), 64'hA4);
        checkOutput("tp_last3", 64'(got_last[3]), 64'h1);
        checkOutput("tp_d4", 64'(got_data[4]), 64'hB1);
        checkOutput("tp_tag4", 64'(got_tag[4]), 64'h0002);
        checkOutput("tp_d7", 64'(got_data[7]), 64'hB4);
        checkOutput("tp_bad_read", 64'(bad_read), 64'd0);

        $display("[TB] underrun");
        clearLog();
        m_ready = 1'b1;
        applyStimulus(32'h0007_0003);
        applyStimulus(32'h0000_0031);
        applyStimulus(32'h0000_0032);
        step(10);
        checkOutput("ur_gap_valid", 64'(m_valid), 64'h0);
        checkOutput("ur_gap_busy", 64'(busy), 64'h1);
        checkOutput("ur_gap_hs", 64'(hs_count), 64'd2);
        checkOutput("ur_gap_done", 64'(done_count), 64'd0);
        applyStimulus(32'h0000_0033);
        step(6);
        checkOutput("ur_hs", 64'(hs_count), 64'd3);
        checkOutput("ur_d2", 64'(got_data[2]), 64'h33);
        checkOutput("ur_last", 64'({got_last[2], got_last[1], got_last[0]}), 64'b100);
        checkOutput("ur_tag", 64'(got_tag[2]), 64'h0007);
        checkOutput("ur_done", 64'(done_count), 64'd1);

        $display("[TB] reset mid-frame");
        clearLog();
        m_ready = 1'b0;
        applyStimulus(32'h0009_0003);
        applyStimulus(32'h0000_0061);
        applyStimulus(32'h0000_0062);
        applyStimulus(32'h0000_0063);
        step(6);
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        checkOutput("mr_hs_before", 64'(hs_count), 64'd1);
        checkOutput("mr_tag_before", 64'(m_tag), 64'h0009);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checkIdle("mid_reset");
        clearLog();
        m_ready = 1'b1;
        applyStimulus(32'h0001_0001);
        applyStimulus(32'h0000_0055);
        step(6);
        checkOutput("mr_hs", 64'(hs_count), 64'd1);
        checkOutput("mr_data", 64'(got_data[0]), 64'h55);
        checkOutput("mr_last", 64'(got_last[0]), 64'h1);
        checkOutput("mr_tag", 64'(got_tag[0]), 64'h0001);
        checkOutput("mr_done", 64'(done_count), 64'd1);
        checkOutput("mr_err", 64'(err_count), 64'd0);
        checkOutput("all_bad_read", 64'(bad_read), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
